// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control path: FSM states, opcodes,
// ALU operand/operation select codes and the bundled control-strobe struct.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_RTYPE  = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDI   = 4'd9,
    S_JUMP   = 4'd10,
    S_FAULT  = 4'd11,
    S_ADDIWB = 4'd12
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  typedef enum logic [1:0] {
    SRCB_RT      = 2'b00,
    SRCB_FOUR    = 2'b01,
    SRCB_IMM     = 2'b10,
    SRCB_IMM_SH2 = 2'b11
  } alu_src_b_e;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_e;

  typedef struct packed {
    logic       pc_en;
    logic       branch_select;
    logic       jump_enable;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
  } ctrl_t;

  // States in which the FSM is stalled on the memory ready handshake.
  function automatic logic is_wait_state(input state_e s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Saturating wait counter for memory handshakes; flags when the last allowed
// stall cycle (MEM_TIMEOUT-1) has been reached.
module mem_wait_timer #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(MEM_TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (count_en && (cnt_q != LAST)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == LAST);

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute, drives PC, memory,
// register-file and ALU controls, stalls on mem_ready and latches a sticky fault.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 5
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_en,
  output logic       branch_select,
  output logic       jump_enable,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       fault,
  output logic [3:0] state_dbg
);

  state_e state_q, state_d;
  logic   fault_q, fault_d;
  ctrl_t  ctrl;
  logic   wait_state;
  logic   wait_expired;
  logic   timed_out;
  logic   branch_taken;
  logic   unused_funct;

  // funct only matters to the ALU decoder downstream (alu_op = funct decode).
  assign unused_funct = ^funct;

  assign wait_state   = is_wait_state(state_q);
  assign timed_out    = wait_state && !mem_ready && wait_expired;
  assign branch_taken = ((opcode == OP_BEQ) && zero) || ((opcode == OP_BNE) && !zero);

  mem_wait_timer #(
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .CNT_W       (CNT_W)
  ) u_wait_timer (
    .clk      (clk),
    .rst      (reset_n),
    .clear    (state_d != state_q),
    .count_en (wait_state && !mem_ready),
    .expired  (wait_expired)
  );

  always_comb begin
    state_d = state_q;
    ctrl    = '0;
    unique case (state_q)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        if (timed_out) begin
          state_d = S_FAULT;
        end else if (mem_ready) begin
          ctrl.ir_write = 1'b1;
          ctrl.pc_en    = 1'b1;
          state_d       = S_DECODE;
        end
      end
      S_DECODE: begin
        ctrl.alu_src_b = SRCB_IMM_SH2;
        case (opcode)
          OP_LW, OP_SW:   state_d = S_MEMADR;
          OP_RTYPE:       state_d = S_RTYPE;
          OP_BEQ, OP_BNE: state_d = S_BRANCH;
          OP_ADDI:        state_d = S_ADDI;
          OP_J:           state_d = S_JUMP;
          default:        state_d = S_FAULT;
        endcase
      end
      S_MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        state_d        = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
        if (timed_out) begin
          state_d = S_FAULT;
        end else if (mem_ready) begin
          state_d = S_MEMWB;
        end
      end
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        state_d         = S_FETCH;
      end
      S_MEMWR: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
        if (timed_out) begin
          state_d = S_FAULT;
        end else if (mem_ready) begin
          state_d = S_FETCH;
        end
      end
      S_RTYPE: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_RT;
        ctrl.alu_op    = ALUOP_FUNCT;
        state_d        = S_ALUWB;
      end
      S_ALUWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
        state_d        = S_FETCH;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_RT;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_en         = branch_taken;
        ctrl.branch_select = branch_taken;
        state_d            = S_FETCH;
      end
      S_ADDI: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        state_d        = S_ADDIWB;
      end
      S_ADDIWB: begin
        ctrl.reg_write = 1'b1;
        state_d        = S_FETCH;
      end
      S_JUMP: begin
        ctrl.pc_en       = 1'b1;
        ctrl.jump_enable = 1'b1;
        state_d          = S_FETCH;
      end
      S_FAULT: begin
        state_d = S_FAULT;
      end
      default: begin
        state_d = S_FAULT;
      end
    endcase

    // Reset overrides everything combinationally so no strobe leaks in the reset cycle.
    if (reset_n) begin
      state_d = S_FETCH;
      ctrl    = '0;
    end

    fault_d = (state_d == S_FAULT);
  end

  always_ff @(posedge clk) begin
    if (reset_n) begin
      state_q <= S_FETCH;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      fault_q <= fault_d;
    end
  end

  assign pc_en         = ctrl.pc_en;
  assign branch_select = ctrl.branch_select;
  assign jump_enable   = ctrl.jump_enable;
  assign iord          = ctrl.iord;
  assign mem_read      = ctrl.mem_read;
  assign mem_write     = ctrl.mem_write;
  assign ir_write      = ctrl.ir_write;
  assign reg_write     = ctrl.reg_write;
  assign reg_dst       = ctrl.reg_dst;
  assign mem_to_reg    = ctrl.mem_to_reg;
  assign alu_src_a     = ctrl.alu_src_a;
  assign alu_src_b     = ctrl.alu_src_b;
  assign alu_op        = ctrl.alu_op;
  assign fault         = fault_q && !reset_n;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Scoreboard bench for mips_multicycle_ctrl: an instruction-level model expands each
// instruction into its expected per-cycle trace; a monitor compares every cycle.
module tb_mips_multicycle_ctrl;
  import mips_ctrl_pkg::*;

  localparam int unsigned TMO = 16;

  logic       clk = 1'b1;
  logic       reset_n;
  logic [5:0] opcode, funct;
  logic       zero, mem_ready;
  logic       pc_en, branch_select, jump_enable, iord, mem_read, mem_write;
  logic       ir_write, reg_write, reg_dst, mem_to_reg, alu_src_a, fault;
  logic [1:0] alu_src_b, alu_op;
  logic [3:0] state_dbg;

  always #5 clk = ~clk;

  mips_multicycle_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(5)) dut (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pc_en(pc_en), .branch_select(branch_select),
    .jump_enable(jump_enable), .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .reg_write(reg_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .fault(fault), .state_dbg(state_dbg)
  );

  typedef struct packed {
    logic [3:0] st;
    logic flt, pc_en, bsel, jen, iord, mrd, mwr, irw, rw, rdst, m2r, asa;
    logic [1:0] asb, aop;
  } obs_t;

  typedef struct {
    bit    chk;
    obs_t  o;
    string tag;
  } exp_t;

  typedef struct {
    logic       rst;
    logic [5:0] op, fn;
    logic       z, rdy;
  } stim_t;

  stim_t stim_q[$];
  exp_t  exp_q[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc    = 0;

  localparam logic [5:0] LEGAL [7] = '{OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_BNE, OP_ADDI, OP_J};

  function automatic logic rbit();
    return 1'($urandom);
  endfunction

  function automatic obs_t base(input state_e st);
    obs_t o;
    o    = '0;
    o.st = st;
    return o;
  endfunction

  function automatic int unsigned rwait();
    int unsigned r;
    r = $urandom_range(0, 19);
    if (r < 15) return r % 4;
    if (r < 18) return TMO - 1;
    return TMO;
  endfunction

  function automatic logic [5:0] rillegal();
    logic [5:0] v;
    v = 6'h3F;
    for (int k = 0; k < 50; k++) begin
      v = 6'($urandom);
      if (!(v inside {OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_BNE, OP_ADDI, OP_J})) break;
      v = 6'h3F;
    end
    return v;
  endfunction

  task automatic emit(input logic rst, input logic [5:0] op, input logic z, input logic rdy,
                      input obs_t o, input bit chk, input string tag);
    stim_t s;
    exp_t  e;
    s.rst = rst; s.op = op; s.fn = 6'($urandom); s.z = z; s.rdy = rdy;
    e.chk = chk; e.o = o; e.tag = tag;
    stim_q.push_back(s);
    exp_q.push_back(e);
  endtask

  task automatic gen_reset(input state_e prev, input bit chk);
    emit(1'b1, 6'($urandom), rbit(), rbit(), base(prev), chk, "reset_cycle");
  endtask

  task automatic gen_fault(input int unsigned n);
    obs_t o;
    o = base(S_FAULT);
    o.flt = 1'b1;
    for (int unsigned i = 0; i < n; i++) emit(1'b0, 6'($urandom), rbit(), rbit(), o, 1, "fault_hold");
  endtask

  // w stall cycles before mem_ready; w >= TMO means the handshake never completes.
  task automatic gen_fetch(input int unsigned w, output bit faulted);
    obs_t o;
    o = base(S_FETCH);
    o.mrd = 1'b1;
    o.asb = 2'b01;
    faulted = (w >= TMO);
    for (int unsigned i = 0; i < w && i < TMO; i++)
      emit(1'b0, 6'($urandom), rbit(), 1'b0, o, 1, "fetch_wait");
    if (!faulted) begin
      o.pc_en = 1'b1;
      o.irw   = 1'b1;
      emit(1'b0, 6'($urandom), rbit(), 1'b1, o, 1, "fetch_ready");
    end
  endtask

  task automatic gen_memwait(input state_e st, input logic [5:0] op, input int unsigned w,
                             output bit faulted);
    obs_t o;
    o = base(st);
    o.iord = 1'b1;
    if (st == S_MEMRD) o.mrd = 1'b1;
    else               o.mwr = 1'b1;
    faulted = (w >= TMO);
    for (int unsigned i = 0; i < w && i < TMO; i++) emit(1'b0, op, rbit(), 1'b0, o, 1, "mem_wait");
    if (!faulted) emit(1'b0, op, rbit(), 1'b1, o, 1, "mem_ready");
  endtask

  task automatic gen_instr(input logic [5:0] op, input logic z, input int unsigned fw,
                           input int unsigned mw);
    bit   f;
    obs_t o;
    logic taken;
    gen_fetch(fw, f);
    if (f) begin
      gen_fault(3);
      gen_reset(S_FAULT, 1);
      return;
    end
    o = base(S_DECODE); o.asb = 2'b11;
    emit(1'b0, op, rbit(), rbit(), o, 1, "decode");
    case (op)
      OP_LW, OP_SW: begin
        o = base(S_MEMADR); o.asa = 1'b1; o.asb = 2'b10;
        emit(1'b0, op, rbit(), rbit(), o, 1, "memadr");
        gen_memwait((op == OP_LW) ? S_MEMRD : S_MEMWR, op, mw, f);
        if (f) begin
          gen_fault(3);
          gen_reset(S_FAULT, 1);
        end else if (op == OP_LW) begin
          o = base(S_MEMWB); o.rw = 1'b1; o.m2r = 1'b1;
          emit(1'b0, op, rbit(), rbit(), o, 1, "memwb");
        end
      end
      OP_RTYPE: begin
        o = base(S_RTYPE); o.asa = 1'b1; o.aop = 2'b10;
        emit(1'b0, op, rbit(), rbit(), o, 1, "rtype");
        o = base(S_ALUWB); o.rw = 1'b1; o.rdst = 1'b1;
        emit(1'b0, op, rbit(), rbit(), o, 1, "aluwb");
      end
      OP_BEQ, OP_BNE: begin
        taken = (op == OP_BEQ) ? z : ~z;
        o = base(S_BRANCH); o.asa = 1'b1; o.aop = 2'b01; o.pc_en = taken; o.bsel = taken;
        emit(1'b0, op, z, rbit(), o, 1, "branch");
      end
      OP_ADDI: begin
        o = base(S_ADDI); o.asa = 1'b1; o.asb = 2'b10;
        emit(1'b0, op, rbit(), rbit(), o, 1, "addi");
        o = base(S_ADDIWB); o.rw = 1'b1;
        emit(1'b0, op, rbit(), rbit(), o, 1, "addiwb");
      end
      OP_J: begin
        o = base(S_JUMP); o.pc_en = 1'b1; o.jen = 1'b1;
        emit(1'b0, op, rbit(), rbit(), o, 1, "jump");
      end
      default: begin
        gen_fault(20);
        gen_reset(S_FAULT, 1);
      end
    endcase
  endtask

  initial begin
    stim_t s;
    bit    f;
    obs_t  o;
    reset_n = 1'b1; opcode = '0; funct = '0; zero = 1'b0; mem_ready = 1'b0;

    gen_reset(S_FETCH, 0);
    gen_reset(S_FETCH, 1);
    gen_instr(OP_RTYPE, 1'b0, 0, 0);
    gen_instr(OP_LW, 1'b0, 0, 3);
    gen_instr(OP_BEQ, 1'b1, 1, 0);
    gen_instr(OP_BEQ, 1'b0, 0, 0);
    gen_instr(OP_BNE, 1'b0, 2, 0);
    gen_instr(OP_BNE, 1'b1, 0, 0);
    gen_instr(OP_J, 1'b0, 0, 0);
    gen_instr(OP_SW, 1'b0, 0, 2);
    gen_instr(OP_ADDI, 1'b0, 1, 0);
    gen_instr(OP_LW, 1'b0, TMO - 1, TMO - 1);
    gen_instr(6'h3F, 1'b0, 0, 0);
    gen_instr(OP_RTYPE, 1'b0, TMO, 0);
    gen_instr(OP_LW, 1'b0, 0, TMO);
    gen_instr(OP_SW, 1'b0, 0, TMO);

    // Reset in the middle of a store wait, then a full-length fetch stall.
    gen_fetch(0, f);
    o = base(S_DECODE); o.asb = 2'b11;
    emit(1'b0, OP_SW, 1'b0, 1'b0, o, 1, "decode");
    o = base(S_MEMADR); o.asa = 1'b1; o.asb = 2'b10;
    emit(1'b0, OP_SW, 1'b0, 1'b0, o, 1, "memadr");
    o = base(S_MEMWR); o.mwr = 1'b1; o.iord = 1'b1;
    for (int i = 0; i < 3; i++) emit(1'b0, OP_SW, 1'b0, 1'b0, o, 1, "memwr_wait");
    gen_reset(S_MEMWR, 1);
    gen_instr(OP_ADDI, 1'b0, TMO - 1, 0);

    // Reset in the middle of a fetch stall must restart the timeout window.
    o = base(S_FETCH); o.mrd = 1'b1; o.asb = 2'b01;
    for (int i = 0; i < 5; i++) emit(1'b0, 6'($urandom), 1'b0, 1'b0, o, 1, "fetch_wait");
    gen_reset(S_FETCH, 1);
    gen_instr(OP_J, 1'b0, TMO - 1, 0);

    repeat (60) begin
      if ($urandom_range(0, 15) == 0)
        gen_instr(rillegal(), rbit(), rwait(), rwait());
      else
        gen_instr(LEGAL[$urandom_range(0, 6)], rbit(), rwait(), rwait());
    end
    gen_instr(OP_RTYPE, 1'b0, 0, 0);

    while (stim_q.size() != 0) begin
      s = stim_q.pop_front();
      reset_n = s.rst; opcode = s.op; funct = s.fn; zero = s.z; mem_ready = s.rdy;
      @(posedge clk);
      #1;
    end

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d expected cycles left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    exp_t e;
    obs_t a;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        a = {state_dbg, fault, pc_en, branch_select, jump_enable, iord, mem_read, mem_write,
             ir_write, reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op};
        if (e.chk) begin
          checks++;
          if (a !== e.o) begin
            errors++;
            $display("FAIL %s cycle=%0d got st=%0d {flt,pc,bs,jen,iord,rd,wr,irw,rw,rdst,m2r,asa}=%b asb=%b aop=%b, exp st=%0d %b asb=%b aop=%b",
                     e.tag, cyc, a.st,
                     {a.flt, a.pc_en, a.bsel, a.jen, a.iord, a.mrd, a.mwr, a.irw, a.rw, a.rdst, a.m2r, a.asa},
                     a.asb, a.aop, e.o.st,
                     {e.o.flt, e.o.pc_en, e.o.bsel, e.o.jen, e.o.iord, e.o.mrd, e.o.mwr, e.o.irw, e.o.rw, e.o.rdst, e.o.m2r, e.o.asa},
                     e.o.asb, e.o.aop);
          end
        end
      end
      cyc++;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached with %0d cycles pending", exp_q.size());
    $fatal(1, "watchdog expired");
  end

endmodule
